// File: rtl/alarm_pkg.sv
// Shared types for the alarm ring controller: FSM state encoding,
// time word width and a small state-decode helper.
package alarm_pkg;

    localparam int TIME_W = 14;

    typedef enum logic [1:0] {
        ALM_IDLE,
        ALM_RINGING,
        ALM_SNOOZE,
        ALM_DONE
    } alm_state_t;

    function automatic logic is_active(alm_state_t s);
        return (s == ALM_RINGING) || (s == ALM_SNOOZE);
    endfunction

endpackage

// File: rtl/beep_pattern_gen.sv
// Buzzer on/off cadence: BEEP_ON beep ticks on, BEEP_OFF ticks off, repeating.
// Ports: clk, rst_n, en (ringing), restart (begin in ON phase),
//        beep_Tick (cadence pulse), beep_Out (registered buzzer level).
module beep_pattern_gen #(
    parameter int BEEP_ON  = 4,
    parameter int BEEP_OFF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    input  logic beep_Tick,
    output logic beep_Out
);

    localparam int MAXP = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    logic [CW-1:0] cnt;
    logic          on_ph;
    logic          last;

    // Final tick of whichever phase is running.
    assign last = on_ph ? (cnt == CW'(BEEP_ON - 1))
                        : (cnt == CW'(BEEP_OFF - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            on_ph    <= 1'b0;
            beep_Out <= 1'b0;
        end else if (restart) begin
            // A tick coinciding with the restart is not counted.
            cnt      <= '0;
            on_ph    <= 1'b1;
            beep_Out <= en;
        end else if (!en) begin
            cnt      <= '0;
            on_ph    <= 1'b0;
            beep_Out <= 1'b0;
        end else if (beep_Tick) begin
            if (last) begin
                cnt      <= '0;
                on_ph    <= ~on_ph;
                beep_Out <= ~on_ph;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer: rings on alarm-time match, supports limited snooze,
// stops on puzzle solve or ring timeout, drives the buzzer.
// Ports: clk, rst_n, time_Dat/alm_Dat (compared), alm_Enable (arm),
//        min_Tick, beep_Tick, snooze_Btn, puzzle_Solved (inputs);
//        alm_Sound_Out, alm_Active, puzzle_Start, snooze_Left (outputs).
module alarm_ring_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN  = 5,
    parameter int MAX_SNOOZE  = 3,
    parameter int TIMEOUT_MIN = 30,
    parameter int BEEP_ON     = 4,
    parameter int BEEP_OFF    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] time_Dat,
    input  logic [TIME_W-1:0] alm_Dat,
    input  logic              alm_Enable,
    input  logic              min_Tick,
    input  logic              beep_Tick,
    input  logic              snooze_Btn,
    input  logic              puzzle_Solved,
    output logic              alm_Sound_Out,
    output logic              alm_Active,
    output logic              puzzle_Start,
    output logic [1:0]        snooze_Left
);

    alm_state_t state;
    alm_state_t state_nxt;

    logic       match;
    logic       match_q;
    logic       match_rise;
    logic [5:0] ring_cnt;
    logic [3:0] snz_cnt;
    logic [1:0] snooze_used;
    logic       ring_end;
    logic       snz_end;
    logic       snooze_ok;
    logic       ringing;
    logic       ring_entry;
    logic       snz_entry;
    logic       start_entry;
    logic       ring_entry_q;
    logic       start_q;

    assign match      = (time_Dat == alm_Dat);
    assign match_rise = match & ~match_q;

    assign ring_end  = min_Tick && (ring_cnt == 6'(TIMEOUT_MIN - 1));
    assign snz_end   = min_Tick && (snz_cnt == 4'(SNOOZE_MIN - 1));
    assign snooze_ok = snooze_Btn && (snooze_used < 2'(MAX_SNOOZE));

    // Priority: disarm, puzzle solve, timeout, snooze, snooze expiry,
    // new alarm, leaving the alarm minute.
    always_comb begin
        state_nxt = state;
        if (!alm_Enable) begin
            state_nxt = ALM_IDLE;
        end else begin
            case (state)
                ALM_RINGING: begin
                    if (puzzle_Solved)  state_nxt = ALM_DONE;
                    else if (ring_end)  state_nxt = ALM_DONE;
                    else if (snooze_ok) state_nxt = ALM_SNOOZE;
                end
                ALM_SNOOZE: begin
                    if (puzzle_Solved) state_nxt = ALM_DONE;
                    else if (snz_end)  state_nxt = ALM_RINGING;
                end
                ALM_IDLE: begin
                    if (match_rise) state_nxt = ALM_RINGING;
                end
                ALM_DONE: begin
                    // Held until the matching minute has passed.
                    if (!match) state_nxt = ALM_IDLE;
                end
                default: state_nxt = ALM_IDLE;
            endcase
        end
    end

    assign ringing     = (state == ALM_RINGING);
    assign ring_entry  = (state_nxt == ALM_RINGING) && !ringing;
    assign snz_entry   = (state_nxt == ALM_SNOOZE) && (state != ALM_SNOOZE);
    assign start_entry = (state == ALM_IDLE) && (state_nxt == ALM_RINGING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ALM_IDLE;
            match_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            match_q <= match;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_cnt <= '0;
        end else if (ring_entry) begin
            ring_cnt <= '0;
        end else if (ringing && min_Tick) begin
            ring_cnt <= ring_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snz_cnt <= '0;
        end else if (snz_entry) begin
            snz_cnt <= '0;
        end else if ((state == ALM_SNOOZE) && min_Tick) begin
            snz_cnt <= snz_cnt + 4'd1;
        end
    end

    // Snooze budget lasts for the whole alarm event, across re-rings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snooze_used <= '0;
        end else if (state_nxt == ALM_IDLE) begin
            snooze_used <= '0;
        end else if (snz_entry) begin
            snooze_used <= snooze_used + 2'd1;
        end
    end

    // One-cycle delay aligns puzzle_Start with the first buzzer-on cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_entry_q <= 1'b0;
            start_q      <= 1'b0;
            puzzle_Start <= 1'b0;
        end else begin
            ring_entry_q <= ring_entry;
            start_q      <= start_entry;
            puzzle_Start <= start_q;
        end
    end

    beep_pattern_gen #(
        .BEEP_ON  (BEEP_ON),
        .BEEP_OFF (BEEP_OFF)
    ) u_beep (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ringing),
        .restart   (ring_entry_q),
        .beep_Tick (beep_Tick),
        .beep_Out  (alm_Sound_Out)
    );

    assign alm_Active  = is_active(state);
    assign snooze_Left = 2'(MAX_SNOOZE) - snooze_used;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Randomized scoreboard bench for alarm_ring_controller with a
// behavioural reference model of the ringing/snooze/stop rules.
module tb_alarm_ring_controller;

    localparam int SNOOZE_MIN  = 5;
    localparam int MAX_SNOOZE  = 3;
    localparam int TIMEOUT_MIN = 30;
    localparam int BEEP_ON     = 4;
    localparam int BEEP_OFF    = 4;
    localparam int NCYC        = 20000;
    localparam logic [13:0] ALM = 14'd420;

    logic        clk;
    logic        rst_n;
    logic [13:0] time_Dat;
    logic [13:0] alm_Dat;
    logic        alm_Enable;
    logic        min_Tick;
    logic        beep_Tick;
    logic        snooze_Btn;
    logic        puzzle_Solved;
    logic        alm_Sound_Out;
    logic        alm_Active;
    logic        puzzle_Start;
    logic [1:0]  snooze_Left;

    alarm_ring_controller #(
        .SNOOZE_MIN  (SNOOZE_MIN),
        .MAX_SNOOZE  (MAX_SNOOZE),
        .TIMEOUT_MIN (TIMEOUT_MIN),
        .BEEP_ON     (BEEP_ON),
        .BEEP_OFF    (BEEP_OFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .time_Dat      (time_Dat),
        .alm_Dat       (alm_Dat),
        .alm_Enable    (alm_Enable),
        .min_Tick      (min_Tick),
        .beep_Tick     (beep_Tick),
        .snooze_Btn    (snooze_Btn),
        .puzzle_Solved (puzzle_Solved),
        .alm_Sound_Out (alm_Sound_Out),
        .alm_Active    (alm_Active),
        .puzzle_Start  (puzzle_Start),
        .snooze_Left   (snooze_Left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       snd;
        logic       act;
        logic       start;
        logic [1:0] left;
    } exp_t;

    typedef enum int {M_IDLE, M_RING, M_SNZ, M_DONE} mst_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    mst_t ms;
    bit   m_match_q;
    bit   m_entered;
    bit   m_pend;
    int   m_ring_min;
    int   m_snz_min;
    int   m_used;
    int   m_pos;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ms         = M_IDLE;
        m_match_q  = 0;
        m_entered  = 0;
        m_pend     = 0;
        m_ring_min = 0;
        m_snz_min  = 0;
        m_used     = 0;
        m_pos      = 0;
    endtask

    // One clock of the alarm rules; pushes the outputs expected after it.
    task automatic model_step();
        bit   m;
        bit   rise;
        bit   snd;
        bit   start;
        mst_t nx;
        exp_t e;
        m    = (time_Dat == alm_Dat);
        rise = m && !m_match_q;
        nx   = ms;
        if (!alm_Enable)
            nx = M_IDLE;
        else if ((ms == M_RING || ms == M_SNZ) && puzzle_Solved)
            nx = M_DONE;
        else if (ms == M_RING && min_Tick && m_ring_min == TIMEOUT_MIN - 1)
            nx = M_DONE;
        else if (ms == M_RING && snooze_Btn && m_used < MAX_SNOOZE)
            nx = M_SNZ;
        else if (ms == M_SNZ && min_Tick && m_snz_min == SNOOZE_MIN - 1)
            nx = M_RING;
        else if (ms == M_IDLE && rise)
            nx = M_RING;
        else if (ms == M_DONE && !m)
            nx = M_IDLE;

        if (ms == M_RING && min_Tick) m_ring_min++;
        if (ms == M_SNZ && min_Tick) m_snz_min++;
        if (nx == M_RING && ms != M_RING) m_ring_min = 0;
        if (nx == M_SNZ && ms != M_SNZ) m_snz_min = 0;
        if (nx == M_SNZ && ms == M_RING) m_used++;
        if (nx == M_IDLE) m_used = 0;

        if (m_entered) begin
            m_pos = 0;
            snd   = 1;
        end else if (ms == M_RING) begin
            if (beep_Tick) m_pos = (m_pos + 1) % (BEEP_ON + BEEP_OFF);
            snd = (m_pos < BEEP_ON);
        end else begin
            snd = 0;
        end

        start     = m_pend;
        m_pend    = (ms == M_IDLE && nx == M_RING);
        m_entered = (nx == M_RING && ms != M_RING);
        m_match_q = m;
        ms        = nx;

        e.snd   = snd;
        e.act   = (nx == M_RING || nx == M_SNZ);
        e.start = start;
        e.left  = 2'(MAX_SNOOZE - m_used);
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sound"}, int'(alm_Sound_Out), 0);
        check({tag, " active"}, int'(alm_Active), 0);
        check({tag, " start"}, int'(puzzle_Start), 0);
        check({tag, " left"}, int'(snooze_Left), MAX_SNOOZE);
    endtask

    // Monitor: compares whatever the DUT shows just after each edge.
    initial begin
        exp_t e;
        int   mc;
        mc = 0;
        forever begin
            @(posedge clk);
            #2;
            mc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("c%0d sound", mc), int'(alm_Sound_Out), int'(e.snd));
                check($sformatf("c%0d active", mc), int'(alm_Active), int'(e.act));
                check($sformatf("c%0d start", mc), int'(puzzle_Start), int'(e.start));
                check($sformatf("c%0d left", mc), int'(snooze_Left), int'(e.left));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Per-phase odds: 1-in-N for snooze, puzzle, minute tick.
    int snz_d[5] = '{30, 8, 60, 200, 15};
    int puz_d[5] = '{200, 400, 100, 3000, 300};
    int min_d[5] = '{4, 3, 2, 2, 3};

    initial begin
        int ph;
        rst_n         = 1'b0;
        time_Dat      = ALM - 14'd1;
        alm_Dat       = ALM;
        alm_Enable    = 1'b1;
        min_Tick      = 1'b0;
        beep_Tick     = 1'b0;
        snooze_Btn    = 1'b0;
        puzzle_Solved = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ph = cyc / (NCYC / 5);
            if (ms == M_RING && $urandom_range(0, 150) == 0) begin
                #1 rst_n = 1'b0;
                #1 check_reset_outputs($sformatf("async c%0d", cyc));
                model_reset();
                #1 rst_n = 1'b1;
            end
            if ($urandom_range(0, 39) == 0)
                time_Dat = ALM + 14'($urandom_range(0, 2)) - 14'd1;
            if ($urandom_range(0, 999) == 0)
                alm_Dat = 14'($urandom);
            else if ($urandom_range(0, 49) == 0)
                alm_Dat = ALM;
            if (alm_Enable)
                alm_Enable = ($urandom_range(0, (ms == M_SNZ) ? 40 : 600) != 0);
            else
                alm_Enable = ($urandom_range(0, 5) == 0);
            min_Tick      = ($urandom_range(0, min_d[ph] - 1) == 0);
            beep_Tick     = ($urandom_range(0, 1) == 0);
            snooze_Btn    = ($urandom_range(0, snz_d[ph] - 1) == 0);
            puzzle_Solved = ($urandom_range(0, puz_d[ph] - 1) == 0);
            model_step();
        end
        @(negedge clk);
        min_Tick      = 1'b0;
        snooze_Btn    = 1'b0;
        puzzle_Solved = 1'b0;
        @(posedge clk);
        #4;
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
